// File: rtl/ins_decode_seq.sv
// ---------------------------------------------------------------------------
// ins_decode_seq
//
// Purpose:
//   Instruction register, fetch/execute phase bit, CF/ZF flag registers,
//   halt latch and retired-instruction counter for the model machine.
//   Decodes the instruction register into the one-hot instruction lines
//   that the control-signal generator consumes. It also applies the ir_ld,
//   sm_en, cf_en and zf_en strobes that the generator drives back.
//
// Handshake / strobe semantics:
//   There is no valid/ready pair. Every strobe is sampled on the rising
//   clk edge and is qualified by the current phase:
//   - ir_ld acts only in fetch (sm=0).
//   - cf_en and zf_en act only in execute (sm=1).
//   - sm_en advances the phase only while the block is not halted.
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   dbus[7:0]      data bus; carries the instruction byte during fetch
//   ir_ld          load IR from dbus (acts in fetch only)
//   sm_en          phase-advance enable
//   cf_en, zf_en   flag update enables (act in execute only)
//   alu_cf, alu_zf carry/zero results from the ALU/shifter
//   ir[7:0]        instruction register
//   sm             phase: 0 = fetch, 1 = execute (also the FSM state)
//   movea..halt    one-hot instruction lines (all 0 during fetch)
//   cf, zf         flag registers
//   halted         sticky halt status
//   icount         retired-instruction counter, wraps
// ---------------------------------------------------------------------------
module ins_decode_seq #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       dbus,
    input  logic             ir_ld,
    input  logic             sm_en,
    input  logic             cf_en,
    input  logic             zf_en,
    input  logic             alu_cf,
    input  logic             alu_zf,
    output logic [7:0]       ir,
    output logic             sm,
    output logic             movea,
    output logic             moveb,
    output logic             movec,
    output logic             add,
    output logic             sub,
    output logic             and1,
    output logic             not1,
    output logic             rsr,
    output logic             rsl,
    output logic             jmp,
    output logic             jz,
    output logic             jc,
    output logic             in1,
    output logic             out1,
    output logic             nop,
    output logic             halt,
    output logic             cf,
    output logic             zf,
    output logic             halted,
    output logic [CNT_W-1:0] icount
);

    typedef enum logic {
        PH_FETCH = 1'b0,
        PH_EXEC  = 1'b1
    } phase_t;

    // Bit positions inside the packed one-hot decode vector.
    localparam int B_HALT  = 0;
    localparam int B_NOP   = 1;
    localparam int B_OUT1  = 2;
    localparam int B_IN1   = 3;
    localparam int B_JC    = 4;
    localparam int B_JZ    = 5;
    localparam int B_JMP   = 6;
    localparam int B_RSL   = 7;
    localparam int B_RSR   = 8;
    localparam int B_NOT1  = 9;
    localparam int B_AND1  = 10;
    localparam int B_SUB   = 11;
    localparam int B_ADD   = 12;
    localparam int B_MOVEC = 13;
    localparam int B_MOVEB = 14;
    localparam int B_MOVEA = 15;

    phase_t           sm_q, sm_d;
    logic [7:0]       ir_q, ir_d;
    logic             cf_q, cf_d;
    logic             zf_q, zf_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] icount_q, icount_d;

    logic [15:0]      dec_raw;   // decode of ir_q alone, not gated by phase
    logic [15:0]      dec_out;   // gated lines driven to the ports
    logic             advance;   // phase may move this cycle

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sm_q     <= PH_FETCH;
            ir_q     <= 8'h00;
            cf_q     <= 1'b0;
            zf_q     <= 1'b0;
            halted_q <= 1'b0;
            icount_q <= '0;
        end else begin
            sm_q     <= sm_d;
            ir_q     <= ir_d;
            cf_q     <= cf_d;
            zf_q     <= zf_d;
            halted_q <= halted_d;
            icount_q <= icount_d;
        end
    end

    // ------------------------------------------------------------------
    // Raw opcode decode. Rd = ir[3:2] selects within the jump group.
    // Rs = ir[1:0] selects within the shift group.
    // ------------------------------------------------------------------
    always_comb begin
        dec_raw = 16'h0000;
        case (ir_q[7:4])
            4'h0: dec_raw[B_NOP]   = 1'b1;
            4'h1: dec_raw[B_IN1]   = 1'b1;
            4'h2: dec_raw[B_OUT1]  = 1'b1;
            4'h3: dec_raw[B_MOVEA] = 1'b1;
            4'h4: dec_raw[B_MOVEB] = 1'b1;
            4'h5: dec_raw[B_MOVEC] = 1'b1;
            4'h6: begin
                case (ir_q[3:2])
                    2'b00:   dec_raw[B_JMP] = 1'b1;
                    2'b01:   dec_raw[B_JZ]  = 1'b1;
                    2'b10:   dec_raw[B_JC]  = 1'b1;
                    default: dec_raw[B_NOP] = 1'b1;
                endcase
            end
            4'h8: dec_raw[B_ADD]   = 1'b1;
            4'h9: dec_raw[B_SUB]   = 1'b1;
            4'hA: dec_raw[B_AND1]  = 1'b1;
            4'hB: dec_raw[B_NOT1]  = 1'b1;
            4'hC: begin
                case (ir_q[1:0])
                    2'b00:   dec_raw[B_RSR] = 1'b1;
                    2'b01:   dec_raw[B_RSL] = 1'b1;
                    default: dec_raw[B_NOP] = 1'b1;
                endcase
            end
            4'hF: dec_raw[B_HALT]  = 1'b1;
            default: dec_raw[B_NOP] = 1'b1;   // 7, D, E are reserved
        endcase
    end

    // ------------------------------------------------------------------
    // Output gating. The lines are silent in fetch. Once halted, only
    // halt is shown, whatever IR holds.
    // ------------------------------------------------------------------
    always_comb begin
        dec_out = 16'h0000;
        if (sm_q == PH_EXEC) begin
            if (halted_q) begin
                dec_out[B_HALT] = 1'b1;
            end else begin
                dec_out = dec_raw;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    assign advance = sm_en && !halted_q;

    always_comb begin
        sm_d     = sm_q;
        ir_d     = ir_q;
        cf_d     = cf_q;
        zf_d     = zf_q;
        halted_d = halted_q;
        icount_d = icount_q;

        // IR is frozen through execute so the decode stays stable.
        if (ir_ld && (sm_q == PH_FETCH)) begin
            ir_d = dbus;
        end

        if (advance) begin
            sm_d = (sm_q == PH_FETCH) ? PH_EXEC : PH_FETCH;
        end

        if (sm_q == PH_EXEC) begin
            if (cf_en) begin
                cf_d = alu_cf;
            end
            if (zf_en) begin
                zf_d = alu_zf;
            end
            if (dec_raw[B_HALT]) begin
                halted_d = 1'b1;
            end
            // Retire on the execute->fetch transition only.
            if (advance) begin
                icount_d = icount_q + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Port mapping
    // ------------------------------------------------------------------
    assign ir     = ir_q;
    assign sm     = sm_q;
    assign cf     = cf_q;
    assign zf     = zf_q;
    assign halted = halted_q;
    assign icount = icount_q;

    assign halt   = dec_out[B_HALT];
    assign nop    = dec_out[B_NOP];
    assign out1   = dec_out[B_OUT1];
    assign in1    = dec_out[B_IN1];
    assign jc     = dec_out[B_JC];
    assign jz     = dec_out[B_JZ];
    assign jmp    = dec_out[B_JMP];
    assign rsl    = dec_out[B_RSL];
    assign rsr    = dec_out[B_RSR];
    assign not1   = dec_out[B_NOT1];
    assign and1   = dec_out[B_AND1];
    assign sub    = dec_out[B_SUB];
    assign add    = dec_out[B_ADD];
    assign movec  = dec_out[B_MOVEC];
    assign moveb  = dec_out[B_MOVEB];
    assign movea  = dec_out[B_MOVEA];

endmodule

// File: doc/ins_decode_seq.md
Name: ins_decode_seq

Overview:
- Upstream partner of the model-machine control-signal generator.
- Holds the instruction register (IR), the fetch/execute phase bit SM, the CF/ZF flag registers, a halt latch and a retired-instruction counter.
- Decodes IR into the one-hot instruction lines that the control-signal generator consumes, and closes the loop on the ir_ld, sm_en, cf_en and zf_en strobes it returns.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- dbus  in  8  data bus; the instruction byte is present here during fetch.
- ir_ld  in  1  load IR from dbus (from the control-signal generator).
- sm_en  in  1  phase-advance enable (low only while HALT is executing).
- cf_en, zf_en  in  1  flag update enables.
- alu_cf, alu_zf  in  1  carry and zero results from the ALU/shifter.
- ir  out  8  instruction register.
- sm  out  1  phase: 0 = fetch, 1 = execute.
- movea, moveb, movec, add, sub, and1, not1, rsr, rsl, jmp, jz, jc, in1, out1, nop, halt  out  1 each  one-hot instruction lines.
- cf, zf  out  1  flag registers.
- halted  out  1  sticky halt status.
- icount  out  CNT_W  number of retired instructions.

Behaviour:
- Reset (async, rst_n=0): ir=8'h00, sm=0, cf=0, zf=0, halted=0, icount=0. All one-hot lines are 0 while sm=0. Reset asserted mid-instruction aborts it immediately.
- IR: loads dbus on a clock edge when ir_ld=1 and sm=0. ir_ld=1 while sm=1 is ignored, so IR holds through execute.
- SM: toggles on a clock edge when sm_en=1 and halted=0; otherwise it holds. With sm_en=0 during fetch, SM stays 0 (stall) and IR still loads if ir_ld=1.
- Opcode decode on ir[7:4]; ir[3:2]=Rd, ir[1:0]=Rs:
  - 0000 nop
  - 0001 in1
  - 0010 out1
  - 0011 movea
  - 0100 moveb
  - 0101 movec
  - 0110 jump group, selected by ir[3:2]: 00 jmp, 01 jz, 10 jc, 11 nop
  - 1000 add
  - 1001 sub
  - 1010 and1
  - 1011 not1
  - 1100 shift group, selected by ir[1:0]: 00 rsr, 01 rsl, others nop
  - 1111 halt
  - 0111, 1101, 1110 nop
- One-hot rules:
  - Exactly one line is high when sm=1 and halted=0; all lines are 0 when sm=0.
  - When halted=1 and sm=1, only halt is high.
  - The lines are combinational from the ir/sm/halted registers, so they are valid in the same cycle.
- Flags:
  - On a clock edge with sm=1: cf<=alu_cf if cf_en=1, and zf<=alu_zf if zf_en=1.
  - Enables seen while sm=0 are ignored.
  - Flags are not otherwise modified, including by jumps.
- Halt: on a clock edge with sm=1 and halt decoded, halted<=1. SM then freezes at 1 irrespective of sm_en. Only rst_n clears halted.
- icount: increments by 1 on every clock edge where sm=1, sm_en=1 and halted=0 (execute→fetch transition). Wraps from all-ones to 0. HALT itself is not counted.
- Timing: one instruction takes 2 cycles (fetch, execute). Two-byte jumps fetch their operand during execute via the generator's ram_dl/pc_ld; this block needs no extra phase.

Test Plan:
- Reset, then dbus=8'h81 (ADD R0,R1) with ir_ld=1, sm_en=1, cf_en=zf_en=1, alu_cf=1, alu_zf=0 -> after edge 1: ir=8'h81, sm=1, add=1; after edge 2: cf=1, zf=0, sm=0, icount=1.
- Load 8'h64 (JZ) -> jz=1 only in the execute cycle; ir_ld=1 during execute with dbus=8'hFF -> ir remains 8'h64.
- Load 8'hC1 -> rsl=1; load 8'hC2 -> nop=1; load 8'h6C -> nop=1; all one-hot lines are 0 in every fetch cycle.
- Load 8'hF0 and drop sm_en in execute -> halted=1; sm stays 1 and halt stays 1 for 20 cycles; icount is unchanged; ir_ld=1 has no effect.
- Pulse rst_n low mid-execute of SUB with cf=1 -> all registers clear immediately, without waiting for a clock edge.
- Force icount to all-ones (CNT_W=4: 15 instructions) and retire one more -> icount=0.
